// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance counter bank.
// PERF_SATURATE_EN makes counters saturate at all-ones.
package perf_pkg;

  localparam int NUM_CNT_DEF    = 8;
  localparam int CNT_WIDTH_DEF  = 32;
  localparam int NUM_EVENTS_DEF = 16;
  localparam int EV_SEL_W       = 6;
  localparam int EV_EXT_W       = 64;

  typedef struct packed {
    logic                clear;
    logic                gate_on_stall;
    logic                enable;
    logic [EV_SEL_W-1:0] event_sel;
  } perf_cfg_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/perf_counter.sv
// One event counter with its config, shadow copy and sticky overflow.
// PERF_SATURATE_EN holds the counter at all-ones instead of wrapping.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int NUM_EVENTS = NUM_EVENTS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] i_events,
  input  logic                  i_stall,
  input  logic                  i_cfg_we,
  input  logic                  i_clear,
  input  logic                  i_gate,
  input  logic                  i_enable,
  input  logic [EV_SEL_W-1:0]   i_sel,
  input  logic                  i_snapshot,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic [CNT_WIDTH-1:0]  o_shadow,
  output logic                  o_overflow
);

  logic                 r_enable;
  logic                 r_gate;
  logic [EV_SEL_W-1:0]  r_sel;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_ovf;

  logic [EV_EXT_W-1:0]  w_ev_ext;
  logic                 w_inc;
  logic                 w_max;

  // Selects past NUM_EVENTS land on zero-extended bits and never fire.
  assign w_ev_ext = EV_EXT_W'(i_events);
  assign w_inc    = r_enable & w_ev_ext[r_sel] & ~(r_gate & i_stall);
  assign w_max    = &r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_gate   <= 1'b0;
      r_sel    <= '0;
      r_count  <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_snapshot)
        r_shadow <= r_count;
      if (i_cfg_we) begin
        r_enable <= i_enable;
        r_gate   <= i_gate;
        r_sel    <= i_sel;
      end
      if (i_cfg_we && i_clear) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_inc) begin
        if (w_max) begin
          r_ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
          r_count <= r_count;
`else
          r_count <= '0;
`endif
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign o_count    = r_count;
  assign o_shadow   = r_shadow;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with config writes, snapshot and reads.
// PERF_SATURATE_EN selects saturating counters (see perf_counter).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT    = NUM_CNT_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int NUM_EVENTS = NUM_EVENTS_DEF,
  localparam int EV_W      = $clog2(NUM_EVENTS),
  localparam int AW        = $clog2(NUM_CNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  stall,
  input  logic                  cfg_write,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [EV_W+2:0]       cfg_wdata,
  input  logic                  snapshot,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_shadow,
  output logic                  rd_resp,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_CNT-1:0]    overflow
);

  perf_cfg_t            w_cfg;
  logic [CNT_WIDTH-1:0] w_count  [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_shadow [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_rd_val;
  logic                 w_accept;

  rd_state_t            r_state;
  rd_state_t            w_state_nxt;
  logic [CNT_WIDTH-1:0] r_rd_data;

  always_comb begin
    w_cfg.clear         = cfg_wdata[EV_W+2];
    w_cfg.gate_on_stall = cfg_wdata[EV_W+1];
    w_cfg.enable        = cfg_wdata[EV_W];
    w_cfg.event_sel     = EV_SEL_W'(cfg_wdata[EV_W-1:0]);
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic w_we;
    assign w_we = cfg_write && (32'(cfg_addr) == i);

    perf_counter #(
      .CNT_WIDTH  (CNT_WIDTH),
      .NUM_EVENTS (NUM_EVENTS)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_events   (events),
      .i_stall    (stall),
      .i_cfg_we   (w_we),
      .i_clear    (w_cfg.clear),
      .i_gate     (w_cfg.gate_on_stall),
      .i_enable   (w_cfg.enable),
      .i_sel      (w_cfg.event_sel),
      .i_snapshot (snapshot),
      .o_count    (w_count[i]),
      .o_shadow   (w_shadow[i]),
      .o_overflow (overflow[i])
    );
  end

  always_comb begin
    w_rd_val = '0;
    if (32'(rd_addr) < NUM_CNT)
      w_rd_val = rd_shadow ? w_shadow[rd_addr] : w_count[rd_addr];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    rd_resp     = 1'b0;
    unique case (r_state)
      RD_IDLE: begin
        w_accept = rd_req;
        if (rd_req)
          w_state_nxt = RD_RESP;
      end
      RD_RESP: begin
        rd_resp     = 1'b1;
        w_state_nxt = RD_IDLE;
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RD_IDLE;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_rd_data <= w_rd_val;
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank against a cycle-level model.
module tb_perf_counter_bank;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int NE = 10;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] events;
  logic          stall;
  logic          cfg_write;
  logic [1:0]    cfg_addr;
  logic [6:0]    cfg_wdata;
  logic          snapshot;
  logic          rd_req;
  logic [1:0]    rd_addr;
  logic          rd_shadow;
  logic          rd_resp;
  logic [CW-1:0] rd_data;
  logic [NC-1:0] overflow;

  int checks = 0;
  int failures = 0;

  int m_cnt [NC];
  int m_shd [NC];
  bit m_ovf [NC];
  bit m_en  [NC];
  bit m_gate[NC];
  int m_sel [NC];
  bit m_resp;
  int m_rdata;

  int got;
  int pulses;

  perf_counter_bank #(
    .NUM_CNT    (NC),
    .CNT_WIDTH  (CW),
    .NUM_EVENTS (NE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .events    (events),
    .stall     (stall),
    .cfg_write (cfg_write),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .snapshot  (snapshot),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_shadow (rd_shadow),
    .rd_resp   (rd_resp),
    .rd_data   (rd_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict next state, clock the DUT, compare, drop strobes.
  task automatic step();
    int  nc [NC];
    int  ns [NC];
    bit  no [NC];
    bit  hit;
    bit  nresp;
    logic [NC-1:0] exp_ovf;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        nc[i] = 0; ns[i] = 0; no[i] = 0;
      end
      nresp = 0;
      m_rdata = 0;
    end else begin
      nresp = 0;
      if (!m_resp && rd_req) begin
        nresp = 1;
        m_rdata = rd_shadow ? m_shd[rd_addr] : m_cnt[rd_addr];
      end
      for (int i = 0; i < NC; i++) begin
        hit = m_en[i] && (m_sel[i] < NE) && !(m_gate[i] && stall);
        if (hit) hit = events[m_sel[i]];
        ns[i] = snapshot ? m_cnt[i] : m_shd[i];
        nc[i] = m_cnt[i];
        no[i] = m_ovf[i];
        if (cfg_write && cfg_addr == i && cfg_wdata[6]) begin
          nc[i] = 0;
          no[i] = 0;
        end else if (hit) begin
          if (m_cnt[i] == MAXV) begin
            no[i] = 1;
`ifdef PERF_SATURATE_EN
            nc[i] = MAXV;
`else
            nc[i] = 0;
`endif
          end else begin
            nc[i] = m_cnt[i] + 1;
          end
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        m_en[i] = 0; m_gate[i] = 0; m_sel[i] = 0;
      end else if (cfg_write && cfg_addr == i) begin
        m_en[i]   = cfg_wdata[4];
        m_gate[i] = cfg_wdata[5];
        m_sel[i]  = int'(cfg_wdata[3:0]);
      end
      m_cnt[i] = nc[i];
      m_shd[i] = ns[i];
      m_ovf[i] = no[i];
      exp_ovf[i] = no[i];
    end
    m_resp = nresp;
    @(posedge clk);
    #1;
    chk("rd_resp", 64'(rd_resp), 64'(m_resp));
    chk("rd_data", 64'(rd_data), 64'(m_rdata));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    cfg_write = 0;
    snapshot  = 0;
    rd_req    = 0;
  endtask

  task automatic cfg(input int a, input bit clr, input bit gate,
                     input bit en, input int sel);
    cfg_write = 1;
    cfg_addr  = 2'(a);
    cfg_wdata = {clr, gate, en, 4'(sel)};
    step();
  endtask

  task automatic rd(input int a, input bit shd, output int val);
    rd_req    = 1;
    rd_addr   = 2'(a);
    rd_shadow = shd;
    step();
    chk("rd_latency", 64'(rd_resp), 64'd1);
    val = int'(rd_data);
    step();
  endtask

  initial begin
    rst = 1; events = '0; stall = 0; cfg_write = 0; cfg_addr = '0;
    cfg_wdata = '0; snapshot = 0; rd_req = 0; rd_addr = '0; rd_shadow = 0;
    m_resp = 0; m_rdata = 0;
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_shd[i] = 0; m_ovf[i] = 0;
      m_en[i] = 0; m_gate[i] = 0; m_sel[i] = 0;
    end
    #1;
    step();
    step();
    rst = 0;
    rd(0, 0, got);
    chk("reset_cnt0", 64'(got), 64'd0);

    // Plain counting on event 3
    cfg(0, 0, 0, 1, 3);
    events[3] = 1;
    repeat (10) step();
    events = '0;
    rd(0, 0, got);
    chk("cnt0_ten", 64'(got), 64'd10);

    // Stall-gated counting: 3 of 8 cycles stalled
    cfg(1, 0, 1, 1, 2);
    events[2] = 1;
    for (int k = 0; k < 8; k++) begin
      stall = (k == 1 || k == 4 || k == 6);
      step();
    end
    events = '0;
    stall = 0;
    rd(1, 0, got);
    chk("cnt1_gated", 64'(got), 64'd5);

    // Overflow at the top of an 8-bit counter, then clear
    cfg(2, 0, 0, 1, 5);
    events[5] = 1;
    repeat (MAXV) step();
    events = '0;
    rd(2, 0, got);
    chk("cnt2_max", 64'(got), 64'(MAXV));
    chk("ovf2_before", 64'(overflow[2]), 64'd0);
    events[5] = 1;
    step();
    events = '0;
    rd(2, 0, got);
`ifdef PERF_SATURATE_EN
    chk("cnt2_over", 64'(got), 64'(MAXV));
`else
    chk("cnt2_over", 64'(got), 64'd0);
`endif
    chk("ovf2_set", 64'(overflow[2]), 64'd1);
    step();
    chk("ovf2_sticky", 64'(overflow[2]), 64'd1);
    cfg(2, 1, 0, 0, 5);
    rd(2, 0, got);
    chk("cnt2_clr", 64'(got), 64'd0);
    chk("ovf2_clr", 64'(overflow[2]), 64'd0);

    // Snapshot coincident with an event
    cfg(3, 1, 0, 1, 7);
    events[7] = 1;
    repeat (41) step();
    snapshot = 1;
    step();
    events = '0;
    rd(3, 1, got);
    chk("shadow3", 64'(got), 64'd41);
    rd(3, 0, got);
    chk("live3", 64'(got), 64'd42);

    // Clear wins over a same-cycle event; back-to-back read requests
    events[7] = 1;
    cfg(3, 1, 0, 1, 7);
    events = '0;
    pulses = 0;
    rd_addr = 2'd3;
    rd_shadow = 0;
    rd_req = 1;
    step();
    pulses += int'(rd_resp);
    got = int'(rd_data);
    rd_req = 1;
    step();
    pulses += int'(rd_resp);
    step();
    pulses += int'(rd_resp);
    chk("b2b_pulses", 64'(pulses), 64'd1);
    chk("cnt3_clr_ev", 64'(got), 64'd0);

    // Event selects at or above NUM_EVENTS never count
    cfg(0, 0, 0, 1, 12);
    events = '1;
    repeat (5) step();
    events = '0;
    rd(0, 0, got);
    chk("sel_oob", 64'(got), 64'd10);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      events = NE'($urandom);
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) begin
        cfg_write = 1;
        cfg_addr  = 2'($urandom);
        cfg_wdata = 7'($urandom);
        cfg_wdata[6] = ($urandom_range(3) == 0);
      end
      snapshot  = ($urandom_range(9) == 0);
      rd_req    = $urandom_range(1);
      rd_addr   = 2'($urandom);
      rd_shadow = $urandom_range(1);
      step();
    end
    events = '0;
    stall = 0;

    // Reach 100 on every counter, then reset in the middle of a read
    for (int i = 0; i < NC; i++) cfg(i, 1, 0, 1, 0);
    events[0] = 1;
    repeat (100) step();
    events = '0;
    rd(1, 0, got);
    chk("cnt1_100", 64'(got), 64'd100);
    rd_req = 1;
    rd_addr = 2'd0;
    step();
    rst = 1;
    step();
    chk("rst_no_resp", 64'(rd_resp), 64'd0);
    rst = 0;
    step();
    chk("rst_no_resp2", 64'(rd_resp), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < NC; i++) begin
      rd(i, 0, got);
      chk("rst_live", 64'(got), 64'd0);
      rd(i, 1, got);
      chk("rst_shadow", 64'(got), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 8: number of counters (2..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 32: counter width in bits (8..64).
REQ-003 SHALL have parameter NUM_EVENTS, default 16: event input count (2..64); EV_W = $clog2(NUM_EVENTS).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port events  input  NUM_EVENTS  per-cycle event strobes (icache stall, dcache miss, flush, branch mispredict, ...).
REQ-007 SHALL have port stall  input  1  pipeline stall, used by stall-gated counters.
REQ-008 SHALL have port cfg_write  input  1  single-cycle config write strobe.
REQ-009 SHALL have port cfg_addr  input  $clog2(NUM_CNT)  counter index written.
REQ-010 SHALL have port cfg_wdata  input  EV_W+3  {clear, gate_on_stall, enable, event_sel[EV_W-1:0]}.
REQ-011 SHALL have port snapshot  input  1  copy all live counters into shadow registers.
REQ-012 SHALL have port rd_req  input  1  read request.
REQ-013 SHALL have port rd_addr  input  $clog2(NUM_CNT)  counter index read.
REQ-014 SHALL have port rd_shadow  input  1  1 = read shadow copy, 0 = live value.
REQ-015 SHALL have port rd_resp  output  1  read data valid, single-cycle pulse.
REQ-016 SHALL have port rd_data  output  CNT_WIDTH  read result.
REQ-017 SHALL have port overflow  output  NUM_CNT  per-counter sticky overflow flag.

Function
REQ-018 Each counter SHALL increment by 1 in a cycle where enable=1 and events[event_sel]=1, and, if gate_on_stall=1, stall=0.
REQ-019 event_sel >= NUM_EVENTS SHALL never count.
REQ-020 cfg_write SHALL latch enable/gate_on_stall/event_sel into the addressed counter at the clock edge; the increment in the write cycle SHALL use the old config.
REQ-021 cfg_write with clear=1 SHALL zero the addressed counter and its overflow flag; clear and increment in the same cycle SHALL leave the counter 0.
REQ-022 Increment from all-ones SHALL wrap to 0 and set overflow[i]; overflow SHALL stay set until clear or rst.
REQ-023 snapshot SHALL copy every live counter into its shadow register at the edge; shadows SHALL capture the pre-increment value of that cycle.
REQ-024 Read FSM SHALL have states IDLE and RESP: IDLE + rd_req -> RESP; RESP -> IDLE unconditionally; rd_resp=1 only in RESP.
REQ-025 rd_data SHALL be sampled when rd_req is accepted (latency 1), giving the value before any same-cycle increment, clear or snapshot.
REQ-026 rd_req asserted in RESP SHALL be ignored; back-to-back reads SHALL therefore complete one per 2 cycles.
REQ-027 rd_data SHALL hold its last value outside RESP.

Reset
REQ-028 rst SHALL zero all counters, shadows, overflow, config fields (enable=0) and rd_data; rd_resp=0; FSM -> IDLE.
REQ-029 rst asserted mid-read SHALL abort the read; no rd_resp pulse follows.

Configuration
REQ-030 With PERF_SATURATE_EN defined, an increment from all-ones SHALL hold the counter at all-ones and still set overflow[i]; without it the counter SHALL wrap per REQ-022.

Structure
REQ-031 Package perf_pkg SHALL hold the perf_cfg_t struct {clear, gate_on_stall, enable, event_sel} and the default parameter constants.
REQ-032 Sub-module perf_counter (one counter + shadow + overflow, CNT_WIDTH parametrised) SHALL be instantiated NUM_CNT times via generate.

Verification
REQ-033 Counter 0 configured event_sel=3, enable=1; pulse events[3] for 10 cycles -> live read of counter 0 returns 10, rd_resp 1 cycle after rd_req.
REQ-034 Counter 1 gate_on_stall=1 on event 2; events[2]=1 for 8 cycles with stall=1 on 3 of them -> counter 1 = 5.
REQ-035 CNT_WIDTH=8, counter at 255 plus one event -> 0 with overflow[i]=1 (PERF_SATURATE_EN: 255, overflow[i]=1); clear -> 0, overflow[i]=0.
REQ-036 Counter at 41, snapshot coincident with event -> shadow read 41, live read 42.
REQ-037 Clear coincident with event -> counter 0; rd_req on consecutive cycles -> second ignored, exactly one rd_resp.
REQ-038 rst asserted while FSM in RESP after counters reached 100 -> no rd_resp, all reads return 0, overflow=0.
